// File: rtl/io_controller_mem_reader.sv
// io_controller_mem_reader
// Avalon-MM read master for the IO controller's on-chip mailbox memory.
// Reads a contiguous, wrap-around block of words and streams them out on a
// valid/ready interface with last-word marking.
// Optional build macro: IO_MEM_READER_CLEAR_ON_READ_EN -- each read is followed
// by a write-zero to the same address, so drained mailbox words are cleared.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start
// ISSUE  | presenting reads while the output buffer has room
// CLEAR  | write-zero to the address just read (clear build only)
// DRAIN  | all reads issued, waiting for the consumer to pop the rest
// DONE   | one-cycle completion pulse, busy already low
module io_controller_mem_reader #(
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 32,
   parameter int DEPTH_WORDS = 2560,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] length,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_chipselect,
   output logic              avm_write,
   output logic [3:0]        avm_byteenable,
   output logic [DATA_W-1:0] avm_writedata,
   output logic              avm_clken,
   input  logic [DATA_W-1:0] avm_readdata,
   output logic [DATA_W-1:0] st_data,
   output logic              st_valid,
   input  logic              st_ready,
   output logic              st_last
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
`ifdef IO_MEM_READER_CLEAR_ON_READ_EN
      , S_CLEAR
`endif
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] issue_cnt_q;
   logic [ADDR_W-1:0] pop_cnt_q;
   logic              busy_q;
   logic              done_q;
   logic              cs_q;
   logic              rd_pend_q;
`ifdef IO_MEM_READER_CLEAR_ON_READ_EN
   logic              wr_q;
`endif

   logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [CNT_W-1:0]  fifo_cnt_q;

   logic              rd_issue;
   logic              push;
   logic              pop;
   logic              space_ok;
   logic [CNT_W:0]    occ_inflight;
   logic [ADDR_W-1:0] addr_inc;

`ifdef IO_MEM_READER_CLEAR_ON_READ_EN
   assign rd_issue  = cs_q & ~wr_q;
   assign avm_write = wr_q;
`else
   assign rd_issue  = cs_q;
   assign avm_write = 1'b0;
`endif

   // Data for a read presented last cycle is on avm_readdata now (latency 1).
   assign push = rd_pend_q;
   assign pop  = st_valid & st_ready;

   // Count buffered words plus reads not yet captured, so a newly issued read
   // is always guaranteed a slot even if the consumer never pops.
   assign occ_inflight = {1'b0, fifo_cnt_q} + (CNT_W+1)'(rd_pend_q) + (CNT_W+1)'(rd_issue);
   assign space_ok     = occ_inflight < (CNT_W+1)'(FIFO_DEPTH);

   assign addr_inc = (addr_q == ADDR_W'(DEPTH_WORDS - 1)) ? '0 : addr_q + 1'b1;

   assign busy           = busy_q;
   assign done           = done_q;
   assign avm_address    = addr_q;
   assign avm_chipselect = cs_q;
   assign avm_byteenable = 4'hF;
   assign avm_writedata  = '0;
   assign avm_clken      = 1'b1;

   assign st_valid = (fifo_cnt_q != '0);
   assign st_data  = fifo_q[rd_ptr_q];
   assign st_last  = st_valid && (pop_cnt_q == ADDR_W'(1));

   // Show-ahead output buffer: capture returning read data, pop on handshake.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= avm_readdata;
            wr_ptr_q         <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + 1'b1;
         else if (!push && pop) fifo_cnt_q <= fifo_cnt_q - 1'b1;
      end
   end

   // Command sequencer with registered bus and status outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         issue_cnt_q <= '0;
         pop_cnt_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cs_q        <= 1'b0;
         rd_pend_q   <= 1'b0;
`ifdef IO_MEM_READER_CLEAR_ON_READ_EN
         wr_q        <= 1'b0;
`endif
      end else begin
         rd_pend_q <= rd_issue;
         done_q    <= 1'b0;
         if (pop) pop_cnt_q <= pop_cnt_q - 1'b1;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (length != '0) begin
                     addr_q      <= base_addr;
                     issue_cnt_q <= length - 1'b1;
                     pop_cnt_q   <= length;
                     busy_q      <= 1'b1;
                     cs_q        <= 1'b1;
                     state_q     <= S_ISSUE;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end
               end
            end
`ifdef IO_MEM_READER_CLEAR_ON_READ_EN
            S_ISSUE: begin
               if (cs_q) begin
                  wr_q    <= 1'b1;
                  state_q <= S_CLEAR;
               end else if (space_ok) begin
                  cs_q        <= 1'b1;
                  issue_cnt_q <= issue_cnt_q - 1'b1;
               end
            end
            S_CLEAR: begin
               addr_q <= addr_inc;
               wr_q   <= 1'b0;
               if (issue_cnt_q == '0) begin
                  cs_q    <= 1'b0;
                  state_q <= S_DRAIN;
               end else begin
                  state_q <= S_ISSUE;
                  if (space_ok) begin
                     cs_q        <= 1'b1;
                     issue_cnt_q <= issue_cnt_q - 1'b1;
                  end else begin
                     cs_q <= 1'b0;
                  end
               end
            end
`else
            S_ISSUE: begin
               // addr_q always holds the next address once a read has gone out
               if (cs_q) addr_q <= addr_inc;
               if (issue_cnt_q == '0) begin
                  cs_q    <= 1'b0;
                  state_q <= S_DRAIN;
               end else if (space_ok) begin
                  cs_q        <= 1'b1;
                  issue_cnt_q <= issue_cnt_q - 1'b1;
               end else begin
                  cs_q <= 1'b0;
               end
            end
`endif
            S_DRAIN: begin
               // Look ahead at the final pop so done follows it by one cycle.
               if ((pop_cnt_q == '0) || ((pop_cnt_q == ADDR_W'(1)) && pop)) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_io_controller_mem_reader.sv
// Directed bench for io_controller_mem_reader with a latency-1 memory model.
module tb_io_controller_mem_reader;

   localparam int DEPTH = 2560;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [11:0] base_addr = '0;
   logic [11:0] length = '0;
   logic        busy, done;
   logic [11:0] avm_address;
   logic        avm_chipselect, avm_write, avm_clken;
   logic [3:0]  avm_byteenable;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata = '0;
   logic [31:0] st_data;
   logic        st_valid, st_last;
   logic        st_ready = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;

   io_controller_mem_reader dut (
      .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .length(length),
      .busy(busy), .done(done), .avm_address(avm_address), .avm_chipselect(avm_chipselect),
      .avm_write(avm_write), .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
      .avm_clken(avm_clken), .avm_readdata(avm_readdata), .st_data(st_data),
      .st_valid(st_valid), .st_ready(st_ready), .st_last(st_last)
   );

   always #5 clk = ~clk;

   // Power-on memory contents: mailbox 0x010..0x013 holds A0..A3, the rest a tagged address.
   function automatic logic [31:0] exp_word(input int a);
      if (a >= 16 && a <= 19) return 32'hA0 + 32'(a - 16);
      return 32'hC000_0000 | 32'(a);
   endfunction

   // Latency-1 memory model; written words tracked separately from initial contents.
   bit          written [DEPTH];
   logic [31:0] wmem    [DEPTH];
   always @(posedge clk) begin
      if (avm_chipselect && int'(avm_address) < DEPTH) begin
         if (avm_write) begin
            written[avm_address] <= 1'b1;
            wmem[avm_address]    <= avm_writedata;
         end else begin
            avm_readdata <= written[avm_address] ? wmem[avm_address] : exp_word(int'(avm_address));
         end
      end
   end

   // Bus / stream monitor.
   logic [11:0] rd_addr_q [$];
   logic [12:0] bus_q [$];
   logic [31:0] got_q [$];
   bit          last_q [$];
   int          n_done = 0;
   int          n_cs = 0;
   int          n_busy = 0;
   always @(posedge clk) begin
      if (reset_n) begin
         if (avm_chipselect) begin
            n_cs++;
            bus_q.push_back({avm_write, avm_address});
            if (!avm_write) rd_addr_q.push_back(avm_address);
         end
         if (st_valid && st_ready) begin
            got_q.push_back(st_data);
            last_q.push_back(st_last);
         end
         if (done) n_done++;
         if (busy) n_busy++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic issue_start(input logic [11:0] b, input logic [11:0] l);
      @(negedge clk);
      base_addr = b;
      length    = l;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic wait_done(input int n0, input int budget, input string tag);
      int k = 0;
      while (n_done == n0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(tag, 32'(n_done - n0), 32'd1);
   endtask

   // Compare received words from index g0 against memory at base (with wrap).
   task automatic check_block(input string tag, input int g0, input int base, input int len);
      check({tag, "_count"}, 32'(got_q.size() - g0), 32'(len));
      for (int i = 0; i < len && (g0 + i) < got_q.size(); i++) begin
         check({tag, "_data"}, got_q[g0+i], exp_word((base + i) % DEPTH));
         check({tag, "_last"}, 32'(last_q[g0+i]), 32'(i == len - 1));
      end
   endtask

   initial begin
      int g0, r0, n0, c0, b0, k;
      bit saw_bad;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cs", avm_chipselect, 0);
      check("rst_write", avm_write, 0);
      check("rst_addr", avm_address, 0);
      check("rst_valid", st_valid, 0);
      check("rst_last", st_last, 0);
      check("rst_data", st_data, 0);
      check("const_be", avm_byteenable, 32'hF);
      check("const_wd", avm_writedata, 0);
      check("const_clken", avm_clken, 1);
      reset_n = 1'b1;
      @(negedge clk);

      // Basic block 0x010, length 4
      g0 = got_q.size(); r0 = rd_addr_q.size(); n0 = n_done;
`ifndef IO_MEM_READER_CLEAR_ON_READ_EN
      issue_start(12'h010, 12'd4);
      check("t1_busy_e0", busy, 1);
      check("t1_cs_e0", avm_chipselect, 1);
      check("t1_addr_e0", avm_address, 32'h010);
      check("t1_valid_e0", st_valid, 0);
      @(negedge clk);
      check("t1_valid_e1", st_valid, 0);
      check("t1_addr_e1", avm_address, 32'h011);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t1_valid", st_valid, 1);
         check("t1_data", st_data, 32'hA0 + 32'(i));
         check("t1_last", st_last, 32'(i == 3));
      end
      @(negedge clk);
      check("t1_done", done, 1);
      check("t1_busy_low", busy, 0);
      check("t1_valid_end", st_valid, 0);
      @(negedge clk);
      check("t1_done_pulse", done, 0);
      check("t1_done_count", 32'(n_done - n0), 1);
`else
      issue_start(12'h010, 12'd4);
      wait_done(n0, 60, "t1_done_seen");
`endif
      check_block("t1", g0, 16, 4);

      // Wrap-around 2558, length 4
      g0 = got_q.size(); r0 = rd_addr_q.size(); n0 = n_done;
      issue_start(12'd2558, 12'd4);
      wait_done(n0, 60, "t2_done_seen");
      check("t2_nreads", 32'(rd_addr_q.size() - r0), 4);
      if (rd_addr_q.size() - r0 >= 4) begin
         check("t2_addr0", rd_addr_q[r0],   32'd2558);
         check("t2_addr1", rd_addr_q[r0+1], 32'd2559);
         check("t2_addr2", rd_addr_q[r0+2], 32'd0);
         check("t2_addr3", rd_addr_q[r0+3], 32'd1);
      end
      check_block("t2", g0, 2558, 4);

      // Back-pressure: length 10, st_ready low for 20 cycles
      g0 = got_q.size(); r0 = rd_addr_q.size(); n0 = n_done;
      st_ready = 1'b0;
      issue_start(12'h100, 12'd10);
      repeat (19) @(negedge clk);
      check("t3_stall_reads_le4", 32'(rd_addr_q.size() - r0 <= 4), 1);
      check("t3_stall_valid", st_valid, 1);
      check("t3_stall_head", st_data, exp_word(12'h100));
      check("t3_stall_busy", busy, 1);
      st_ready = 1'b1;
      k = 0;
      saw_bad = 1'b0;
      while (n_done == n0 && k < 80) begin
         @(negedge clk);
         if ((rd_addr_q.size() - r0) - (got_q.size() - g0) > 4) saw_bad = 1'b1;
         k++;
      end
      check("t3_done_seen", 32'(n_done - n0), 1);
      check("t3_outstanding_le4", 32'(saw_bad), 0);
      check_block("t3", g0, 32'h100, 10);
      repeat (3) @(negedge clk);
      check("t3_done_once", 32'(n_done - n0), 1);

      // Zero length: done only, no bus activity, no busy
      n0 = n_done; c0 = n_cs; b0 = n_busy;
      issue_start(12'h020, 12'd0);
      check("t4_done", done, 1);
      check("t4_busy", busy, 0);
      check("t4_cs", avm_chipselect, 0);
      @(negedge clk);
      check("t4_done_pulse", done, 0);
      repeat (2) @(negedge clk);
      check("t4_no_cs", 32'(n_cs - c0), 0);
      check("t4_no_busy", 32'(n_busy - b0), 0);
      check("t4_done_count", 32'(n_done - n0), 1);

      // Ignored start while busy, then reset mid-command after 3 words
      g0 = got_q.size(); r0 = rd_addr_q.size(); n0 = n_done;
      issue_start(12'h200, 12'd8);
      issue_start(12'h300, 12'd2);
      k = 0;
      while (got_q.size() - g0 < 3 && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("t5_three_words", 32'(got_q.size() - g0), 3);
      reset_n = 1'b0;
      #1;
      check("t5_rst_busy", busy, 0);
      check("t5_rst_done", done, 0);
      check("t5_rst_cs", avm_chipselect, 0);
      check("t5_rst_write", avm_write, 0);
      check("t5_rst_addr", avm_address, 0);
      check("t5_rst_valid", st_valid, 0);
      check("t5_rst_last", st_last, 0);
      check("t5_rst_data", st_data, 0);
      saw_bad = 1'b0;
      for (int i = r0; i < rd_addr_q.size(); i++)
         if (rd_addr_q[i] < 12'h200 || rd_addr_q[i] > 12'h207) saw_bad = 1'b1;
      check("t5_start_ignored", 32'(saw_bad), 0);
      for (int i = 0; i < 3 && (g0 + i) < got_q.size(); i++)
         check("t5_pre_rst_data", got_q[g0+i], exp_word(12'h200 + i));
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("t5_no_done", 32'(n_done - n0), 0);
      g0 = got_q.size(); n0 = n_done;
      issue_start(12'h300, 12'd2);
      wait_done(n0, 40, "t5_post_done_seen");
      check_block("t5_post", g0, 32'h300, 2);

`ifdef IO_MEM_READER_CLEAR_ON_READ_EN
      // Clear-on-read: alternating read / write-zero, second pass reads zeros
      g0 = got_q.size(); r0 = bus_q.size(); n0 = n_done;
      issue_start(12'h400, 12'd3);
      wait_done(n0, 60, "t6_done_seen");
      check_block("t6", g0, 32'h400, 3);
      check("t6_bus_count", 32'(bus_q.size() - r0), 6);
      for (int i = 0; i < 6 && (r0 + i) < bus_q.size(); i++) begin
         logic [12:0] e;
         e = {1'(i % 2), 12'(12'h400 + i / 2)};
         check("t6_bus_seq", bus_q[r0+i], e);
      end
      g0 = got_q.size(); n0 = n_done;
      issue_start(12'h400, 12'd3);
      wait_done(n0, 60, "t6b_done_seen");
      check("t6b_count", 32'(got_q.size() - g0), 3);
      for (int i = 0; i < 3 && (g0 + i) < got_q.size(); i++)
         check("t6b_zero", got_q[g0+i], 0);
`endif

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
